ip_arp_aging: RTL and testbench

- Parametrised next-generation next-hop MAC resolver for the router output path; sits between the LPM stage and the output-port process block.
- Holds its own register-based associative ARP table (key = next-hop IP, data = MAC) with per-entry valid, static and age state, so no external CAM is needed.
- Adds hardware aging of dynamic entries, hit-refresh, lookup back-pressure, and hit/miss statistics.

---
 rtl/ip_arp_pkg.sv | 26 ++
 rtl/arp_result_fifo.sv | 76 +++++++
 rtl/ip_arp_aging.sv | 238 +++++++++++++++++++++++
 tb/tb_ip_arp_aging.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_arp_pkg.sv
// Shared constants and helpers for the next-hop MAC resolver.
package ip_arp_pkg;

  // Ceiling log2, used to size address and counter fields.
  function automatic int clog2_fn(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

  // Entry flags are packed as {valid, static, age[AGE_BITS-1:0]}.
  function automatic int flag_valid_bit(input int age_bits);
    return age_bits + 1;
  endfunction

  function automatic int flag_static_bit(input int age_bits);
    return age_bits;
  endfunction

  // Age value at which a dynamic entry is considered expired.
  function automatic int age_max(input int age_bits);
    return (1 << age_bits) - 1;
  endfunction

endpackage

// File: rtl/arp_result_fifo.sv
// Fallthrough result FIFO: the head entry is presented combinationally while not empty.
module arp_result_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic                  not_empty,
  output logic [DEPTH_BITS:0]   occupancy
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0]   FULL_CNT = (DEPTH_BITS + 1)'(DEPTH);
  localparam logic [DEPTH_BITS:0]   CNT_ONE  = (DEPTH_BITS + 1)'(1);
  localparam logic [DEPTH_BITS-1:0] PTR_ONE  = DEPTH_BITS'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      mem_d [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   cnt_q, cnt_d;
  logic                  pop_eff;
  logic                  push_eff;

  // Pointer/count update; a pop on an empty FIFO does nothing, a push only lands when there is room.
  always_comb begin
    pop_eff  = pop && (cnt_q != '0);
    push_eff = push && ((cnt_q != FULL_CNT) || pop_eff);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_eff) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop_eff) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push_eff, pop_eff})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Head is forced to zero while empty so stale storage never reaches the outputs.
  always_comb begin
    not_empty = (cnt_q != '0);
    occupancy = cnt_q;
    head_data = not_empty ? mem_q[rd_ptr_q] : '0;
  end

  // Control state: pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is data only and needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ip_arp_aging.sv
// Next-hop MAC resolver: register ARP table with aging, hit refresh, result FIFO and statistics.
module ip_arp_aging
  import ip_arp_pkg::*;
#(
  parameter int NUM_QUEUES      = 8,
  parameter int KEY_WIDTH       = 32,
  parameter int DATA_WIDTH      = 48,
  parameter int LUT_DEPTH       = 32,
  parameter int LUT_DEPTH_BITS  = clog2_fn(LUT_DEPTH),
  parameter int AGE_BITS        = 4,
  parameter int AGE_TICK_CYCLES = 1000000,
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [KEY_WIDTH-1:0]      next_hop_ip,
  input  logic [NUM_QUEUES-1:0]     lpm_output_port,
  input  logic                      lpm_vld,
  input  logic                      lpm_hit,
  output logic                      lpm_rdy,
  output logic [DATA_WIDTH-1:0]     next_hop_mac,
  output logic [NUM_QUEUES-1:0]     output_port,
  output logic                      arp_mac_vld,
  output logic                      arp_lookup_hit,
  output logic                      lpm_lookup_hit,
  input  logic                      rd_arp_result,
  input  logic [LUT_DEPTH_BITS-1:0] arp_rd_addr,
  input  logic                      arp_rd_req,
  output logic [DATA_WIDTH-1:0]     arp_rd_mac,
  output logic [KEY_WIDTH-1:0]      arp_rd_ip,
  output logic [2+AGE_BITS-1:0]     arp_rd_flags,
  output logic                      arp_rd_ack,
  input  logic [LUT_DEPTH_BITS-1:0] arp_wr_addr,
  input  logic                      arp_wr_req,
  input  logic [DATA_WIDTH-1:0]     arp_wr_mac,
  input  logic [KEY_WIDTH-1:0]      arp_wr_ip,
  input  logic                      arp_wr_valid,
  input  logic                      arp_wr_static,
  output logic                      arp_wr_ack,
  output logic [31:0]               arp_hit_count,
  output logic [31:0]               arp_miss_count
);

  localparam int FIFO_W     = DATA_WIDTH + NUM_QUEUES + 2;
  localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int FLAGS_W    = 2 + AGE_BITS;
  localparam int VLD_BIT    = flag_valid_bit(AGE_BITS);
  localparam int STC_BIT    = flag_static_bit(AGE_BITS);
  localparam int TICK_W     = clog2_fn(AGE_TICK_CYCLES);
  localparam logic [AGE_BITS-1:0] AGE_LIMIT = AGE_BITS'(age_max(AGE_BITS));
  localparam logic [AGE_BITS-1:0] AGE_ONE   = AGE_BITS'(1);
  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(AGE_TICK_CYCLES - 1);
  localparam logic [TICK_W-1:0]   TICK_ONE  = TICK_W'(1);

  // Table state
  logic [KEY_WIDTH-1:0]  ent_ip_q  [LUT_DEPTH];
  logic [KEY_WIDTH-1:0]  ent_ip_d  [LUT_DEPTH];
  logic [DATA_WIDTH-1:0] ent_mac_q [LUT_DEPTH];
  logic [DATA_WIDTH-1:0] ent_mac_d [LUT_DEPTH];
  logic [AGE_BITS-1:0]   ent_age_q [LUT_DEPTH];
  logic [AGE_BITS-1:0]   ent_age_d [LUT_DEPTH];
  logic [LUT_DEPTH-1:0]  ent_vld_q, ent_vld_d;
  logic [LUT_DEPTH-1:0]  ent_stc_q, ent_stc_d;

  // Lookup pipeline
  logic                  accept;
  logic                  vld_p0_q, vld_p0_d;
  logic [KEY_WIDTH-1:0]  key_p0_q, key_p0_d;
  logic [NUM_QUEUES-1:0] port_p0_q, port_p0_d;
  logic                  lpm_hit_p0_q, lpm_hit_p0_d;
  logic                  match_found;
  logic [LUT_DEPTH_BITS-1:0] match_idx;
  logic                  hit_p1;
  logic [DATA_WIDTH-1:0] res_mac;
  logic [FIFO_W-1:0]     fifo_push_data;
  logic [FIFO_W-1:0]     fifo_head;
  logic [FIFO_DEPTH_BITS:0] fifo_occ;

  // Aging, register access and statistics
  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic                  tick;
  logic                  wr_en;
  logic                  rd_ack_q, rd_ack_d;
  logic                  wr_ack_q, wr_ack_d;
  logic [DATA_WIDTH-1:0] rd_mac_q, rd_mac_d;
  logic [KEY_WIDTH-1:0]  rd_ip_q, rd_ip_d;
  logic [FLAGS_W-1:0]    rd_flags_q, rd_flags_d;
  logic [31:0]           hit_cnt_q, hit_cnt_d;
  logic [31:0]           miss_cnt_q, miss_cnt_d;

  // Admission: in-flight lookups reserve a FIFO slot so the FIFO can never overflow.
  always_comb begin
    lpm_rdy = !reset && ((int'(fifo_occ) + int'(vld_p0_q)) < FIFO_DEPTH);
    accept  = lpm_vld && lpm_rdy;
  end

  // Stage p0: capture the lookup request.
  always_comb begin
    vld_p0_d     = accept;
    key_p0_d     = next_hop_ip;
    port_p0_d    = lpm_output_port;
    lpm_hit_p0_d = lpm_hit;
  end

  // Stage p1: parallel compare; scanning downward leaves the lowest matching index.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = LUT_DEPTH - 1; i >= 0; i--) begin
      if (ent_vld_q[i] && (ent_ip_q[i] == key_p0_q)) begin
        match_found = 1'b1;
        match_idx   = LUT_DEPTH_BITS'(i);
      end
    end
    hit_p1         = vld_p0_q && match_found;
    res_mac        = match_found ? ent_mac_q[match_idx] : '0;
    fifo_push_data = {res_mac, port_p0_q, match_found, lpm_hit_p0_q};
  end

  // Aging tick: one pulse each time the counter wraps.
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_ONE;
  end

  // Table update, lowest to highest precedence: tick aging, hit refresh, register write.
  always_comb begin
    ent_ip_d  = ent_ip_q;
    ent_mac_d = ent_mac_q;
    ent_age_d = ent_age_q;
    ent_vld_d = ent_vld_q;
    ent_stc_d = ent_stc_q;
    wr_en     = arp_wr_req && !reset;
    for (int i = 0; i < LUT_DEPTH; i++) begin
      if (tick && ent_vld_q[i] && !ent_stc_q[i] && (ent_age_q[i] != AGE_LIMIT)) begin
        ent_age_d[i] = ent_age_q[i] + AGE_ONE;
        if ((ent_age_q[i] + AGE_ONE) == AGE_LIMIT) begin
          ent_vld_d[i] = 1'b0;
        end
      end
    end
    if (hit_p1) begin
      ent_age_d[match_idx] = '0;
      ent_vld_d[match_idx] = 1'b1;
    end
    if (wr_en && (int'(arp_wr_addr) < LUT_DEPTH)) begin
      ent_ip_d[arp_wr_addr]  = arp_wr_ip;
      ent_mac_d[arp_wr_addr] = arp_wr_mac;
      ent_age_d[arp_wr_addr] = '0;
      ent_vld_d[arp_wr_addr] = arp_wr_valid;
      ent_stc_d[arp_wr_addr] = arp_wr_static;
    end
  end

  // Register read snapshots the current (pre-write) table; acks follow every request cycle.
  always_comb begin
    rd_ack_d   = arp_rd_req;
    wr_ack_d   = arp_wr_req;
    rd_mac_d   = '0;
    rd_ip_d    = '0;
    rd_flags_d = '0;
    if (int'(arp_rd_addr) < LUT_DEPTH) begin
      rd_mac_d                = ent_mac_q[arp_rd_addr];
      rd_ip_d                 = ent_ip_q[arp_rd_addr];
      rd_flags_d[VLD_BIT]     = ent_vld_q[arp_rd_addr];
      rd_flags_d[STC_BIT]     = ent_stc_q[arp_rd_addr];
      rd_flags_d[AGE_BITS-1:0] = ent_age_q[arp_rd_addr];
    end
  end

  // Hit/miss statistics, counted when the result is pushed; both wrap.
  always_comb begin
    hit_cnt_d  = hit_cnt_q  + ((vld_p0_q &&  match_found) ? 32'd1 : 32'd0);
    miss_cnt_d = miss_cnt_q + ((vld_p0_q && !match_found) ? 32'd1 : 32'd0);
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_vld_q  <= '0;
      ent_stc_q  <= '0;
      ent_age_q  <= '{default: '0};
      vld_p0_q   <= 1'b0;
      tick_cnt_q <= '0;
      rd_ack_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      ent_vld_q  <= ent_vld_d;
      ent_stc_q  <= ent_stc_d;
      ent_age_q  <= ent_age_d;
      vld_p0_q   <= vld_p0_d;
      tick_cnt_q <= tick_cnt_d;
      rd_ack_q   <= rd_ack_d;
      wr_ack_q   <= wr_ack_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Data state: qualified by valid bits, so no reset.
  always_ff @(posedge clk) begin
    ent_ip_q     <= ent_ip_d;
    ent_mac_q    <= ent_mac_d;
    key_p0_q     <= key_p0_d;
    port_p0_q    <= port_p0_d;
    lpm_hit_p0_q <= lpm_hit_p0_d;
    rd_mac_q     <= rd_mac_d;
    rd_ip_q      <= rd_ip_d;
    rd_flags_q   <= rd_flags_d;
  end

  // Stage p2: results are presented from the fallthrough FIFO.
  arp_result_fifo #(
    .WIDTH      (FIFO_W),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_result_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (vld_p0_q),
    .push_data (fifo_push_data),
    .pop       (rd_arp_result),
    .head_data (fifo_head),
    .not_empty (arp_mac_vld),
    .occupancy (fifo_occ)
  );

  assign {next_hop_mac, output_port, arp_lookup_hit, lpm_lookup_hit} = fifo_head;
  assign arp_rd_ack     = rd_ack_q;
  assign arp_wr_ack     = wr_ack_q;
  assign arp_rd_mac     = rd_mac_q;
  assign arp_rd_ip      = rd_ip_q;
  assign arp_rd_flags   = rd_flags_q;
  assign arp_hit_count  = hit_cnt_q;
  assign arp_miss_count = miss_cnt_q;

endmodule

// File: tb/tb_ip_arp_aging.sv
// Randomized and directed bench for ip_arp_aging against a transaction-level reference model.
module tb_ip_arp_aging;

  localparam int ND = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] next_hop_ip;
  logic [7:0]  lpm_output_port;
  logic        lpm_vld, lpm_hit, lpm_rdy;
  logic [47:0] next_hop_mac;
  logic [7:0]  output_port;
  logic        arp_mac_vld, arp_lookup_hit, lpm_lookup_hit, rd_arp_result;
  logic [2:0]  arp_rd_addr, arp_wr_addr;
  logic        arp_rd_req, arp_rd_ack, arp_wr_req, arp_wr_ack;
  logic [47:0] arp_rd_mac, arp_wr_mac;
  logic [31:0] arp_rd_ip, arp_wr_ip;
  logic [3:0]  arp_rd_flags;
  logic        arp_wr_valid, arp_wr_static;
  logic [31:0] arp_hit_count, arp_miss_count;

  ip_arp_aging #(
    .NUM_QUEUES(8), .KEY_WIDTH(32), .DATA_WIDTH(48), .LUT_DEPTH(ND), .LUT_DEPTH_BITS(3),
    .AGE_BITS(2), .AGE_TICK_CYCLES(4), .FIFO_DEPTH_BITS(2)
  ) dut (
    .clk(clk), .reset(reset), .next_hop_ip(next_hop_ip), .lpm_output_port(lpm_output_port),
    .lpm_vld(lpm_vld), .lpm_hit(lpm_hit), .lpm_rdy(lpm_rdy), .next_hop_mac(next_hop_mac),
    .output_port(output_port), .arp_mac_vld(arp_mac_vld), .arp_lookup_hit(arp_lookup_hit),
    .lpm_lookup_hit(lpm_lookup_hit), .rd_arp_result(rd_arp_result), .arp_rd_addr(arp_rd_addr),
    .arp_rd_req(arp_rd_req), .arp_rd_mac(arp_rd_mac), .arp_rd_ip(arp_rd_ip),
    .arp_rd_flags(arp_rd_flags), .arp_rd_ack(arp_rd_ack), .arp_wr_addr(arp_wr_addr),
    .arp_wr_req(arp_wr_req), .arp_wr_mac(arp_wr_mac), .arp_wr_ip(arp_wr_ip),
    .arp_wr_valid(arp_wr_valid), .arp_wr_static(arp_wr_static), .arp_wr_ack(arp_wr_ack),
    .arp_hit_count(arp_hit_count), .arp_miss_count(arp_miss_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 0;

  // Reference model state
  typedef struct packed {
    logic [47:0] mac;
    logic [7:0]  port;
    logic        hit;
    logic        lpm;
  } res_t;

  logic [31:0] m_ip  [ND];
  logic [47:0] m_mac [ND];
  bit          m_vld [ND];
  bit          m_stc [ND];
  int          m_age [ND];
  int          m_phase;
  bit          m_inf;
  logic [31:0] m_inf_key;
  logic [7:0]  m_inf_port;
  bit          m_inf_lpm;
  res_t        exp_q[$];
  logic [31:0] m_hits, m_miss;
  bit          m_rd_ack, m_wr_ack, m_rd_v, m_rd_s;
  logic [47:0] m_rd_mac;
  logic [31:0] m_rd_ip;
  int          m_rd_age;

  int acc_cnt = 0;
  int pop_cnt = 0;
  always @(posedge clk) begin
    if (lpm_vld && lpm_rdy) acc_cnt <= acc_cnt + 1;
    if (rd_arp_result && arp_mac_vld) pop_cnt <= pop_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("lpm_rdy", lpm_rdy, !reset && ((exp_q.size() + int'(m_inf)) < 4));
    chk("mac_vld", arp_mac_vld, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      chk("head_mac", next_hop_mac, exp_q[0].mac);
      chk("head_port", output_port, exp_q[0].port);
      chk("head_hit", arp_lookup_hit, exp_q[0].hit);
      chk("head_lpm", lpm_lookup_hit, exp_q[0].lpm);
    end
    chk("rd_ack", arp_rd_ack, m_rd_ack);
    if (m_rd_ack) begin
      chk("rd_valid", arp_rd_flags[3], m_rd_v);
      chk("rd_static", arp_rd_flags[2], m_rd_s);
      if (m_rd_v) begin
        chk("rd_age", arp_rd_flags[1:0], m_rd_age);
        chk("rd_mac", arp_rd_mac, m_rd_mac);
        chk("rd_ip", arp_rd_ip, m_rd_ip);
      end
    end
    chk("wr_ack", arp_wr_ack, m_wr_ack);
    chk("hit_count", arp_hit_count, m_hits);
    chk("miss_count", arp_miss_count, m_miss);
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_next();
    bit   rdy, tick;
    int   hit_idx;
    res_t r;
    if (reset) begin
      for (int i = 0; i < ND; i++) begin m_vld[i] = 0; m_stc[i] = 0; m_age[i] = 0; end
      m_phase = 0; m_inf = 0; exp_q.delete();
      m_hits = 0; m_miss = 0; m_rd_ack = 0; m_wr_ack = 0;
      return;
    end
    rdy = (exp_q.size() + int'(m_inf)) < 4;
    m_wr_ack = arp_wr_req;
    m_rd_ack = arp_rd_req;
    if (arp_rd_req) begin
      m_rd_mac = m_mac[arp_rd_addr]; m_rd_ip = m_ip[arp_rd_addr];
      m_rd_v = m_vld[arp_rd_addr];   m_rd_s = m_stc[arp_rd_addr];
      m_rd_age = m_age[arp_rd_addr];
    end
    if (rd_arp_result && exp_q.size() > 0) void'(exp_q.pop_front());
    hit_idx = -1;
    if (m_inf) begin
      for (int i = ND - 1; i >= 0; i--)
        if (m_vld[i] && m_ip[i] == m_inf_key) hit_idx = i;
      r.mac  = (hit_idx >= 0) ? m_mac[hit_idx] : 48'd0;
      r.port = m_inf_port;
      r.hit  = (hit_idx >= 0);
      r.lpm  = m_inf_lpm;
      exp_q.push_back(r);
      if (hit_idx >= 0) m_hits = m_hits + 1; else m_miss = m_miss + 1;
    end
    m_inf = lpm_vld && rdy;
    m_inf_key = next_hop_ip; m_inf_port = lpm_output_port; m_inf_lpm = lpm_hit;
    tick = (m_phase == 3);
    m_phase = (m_phase + 1) % 4;
    for (int i = 0; i < ND; i++) begin
      if (tick && m_vld[i] && !m_stc[i]) begin
        m_age[i]++;
        if (m_age[i] >= 3) m_vld[i] = 0;
      end
    end
    if (hit_idx >= 0) begin m_age[hit_idx] = 0; m_vld[hit_idx] = 1; end
    if (arp_wr_req) begin
      m_ip[arp_wr_addr] = arp_wr_ip; m_mac[arp_wr_addr] = arp_wr_mac;
      m_vld[arp_wr_addr] = arp_wr_valid; m_stc[arp_wr_addr] = arp_wr_static;
      m_age[arp_wr_addr] = 0;
    end
  endtask

  // One clock: check at negedge, advance the model, return just after the rising edge.
  task automatic step();
    @(negedge clk);
    if (checking) check_outputs();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset = 1; step(); reset = 0;
  endtask

  task automatic wr(input int a, input logic [31:0] ip, input logic [47:0] mac, input bit v, input bit s);
    arp_wr_addr = 3'(a); arp_wr_ip = ip; arp_wr_mac = mac;
    arp_wr_valid = v; arp_wr_static = s; arp_wr_req = 1;
    step();
    arp_wr_req = 0;
  endtask

  // Issue one lookup and wait until its result is at the FIFO head (2 cycles).
  task automatic lkp(input logic [31:0] ip, input logic [7:0] port, input bit lh);
    next_hop_ip = ip; lpm_output_port = port; lpm_hit = lh; lpm_vld = 1;
    step();
    lpm_vld = 0;
    step();
  endtask

  task automatic pop1();
    rd_arp_result = 1; step(); rd_arp_result = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ips [4];
    int a0, p0;
    for (int i = 0; i < ND; i++) begin m_ip[i] = '0; m_mac[i] = '0; end
    reset = 1; next_hop_ip = 0; lpm_output_port = 0; lpm_vld = 0; lpm_hit = 0;
    rd_arp_result = 0; arp_rd_addr = 0; arp_rd_req = 0; arp_wr_addr = 0; arp_wr_req = 0;
    arp_wr_mac = 0; arp_wr_ip = 0; arp_wr_valid = 0; arp_wr_static = 0;
    step(); step();
    chk("rdy_in_reset", lpm_rdy, 0);
    reset = 0;
    checking = 1;
    chk("rst_mac_vld", arp_mac_vld, 0);
    chk("rst_head_mac", next_hop_mac, 0);
    chk("rst_head_port", output_port, 0);
    chk("rst_head_hit", arp_lookup_hit, 0);
    chk("rst_acks", {arp_rd_ack, arp_wr_ack}, 0);
    chk("rst_counts", {arp_hit_count, arp_miss_count}, 0);

    // Basic hit, then miss
    wr(3, 32'h0A000001, 48'h001122334455, 1, 0);
    lkp(32'h0A000001, 8'h04, 1);
    chk("t1_vld", arp_mac_vld, 1);
    chk("t1_mac", next_hop_mac, 48'h001122334455);
    chk("t1_port", output_port, 8'h04);
    chk("t1_hit", {arp_lookup_hit, lpm_lookup_hit}, 2'b11);
    chk("t1_hit_count", arp_hit_count, 1);
    pop1();
    lkp(32'h0A000099, 8'h02, 0);
    chk("t2_mac", next_hop_mac, 0);
    chk("t2_hit", arp_lookup_hit, 0);
    chk("t2_miss_count", arp_miss_count, 1);
    pop1();

    // Aging: dynamic entry 0 expires, static entry 1 survives
    do_reset();
    wr(0, 32'h0B000000, 48'hAAAA00000000, 1, 0);
    wr(1, 32'h0B000001, 48'hBBBB00000001, 1, 1);
    idle(14);
    lkp(32'h0B000000, 8'h01, 1);
    chk("age_dyn_expired", arp_lookup_hit, 0);
    pop1();
    lkp(32'h0B000001, 8'h01, 1);
    chk("age_static_hit", arp_lookup_hit, 1);
    pop1();

    // Hit refresh every 8 cycles keeps the entry alive
    do_reset();
    wr(0, 32'h0C000000, 48'hCCCC00000000, 1, 0);
    rd_arp_result = 1;
    for (int k = 0; k < 6; k++) begin lkp(32'h0C000000, 8'h08, 0); idle(6); end
    rd_arp_result = 0;
    arp_rd_addr = 0; arp_rd_req = 1; step(); arp_rd_req = 0;
    chk("refresh_valid", arp_rd_flags[3], 1);
    chk("refresh_age_le2", arp_rd_flags[1:0] <= 2'd2, 1);
    step();

    // Back-pressure: 6 held requests, 4 accepted
    do_reset();
    a0 = acc_cnt;
    next_hop_ip = 32'h0D000000; lpm_output_port = 8'h10; lpm_hit = 1; lpm_vld = 1;
    idle(6);
    lpm_vld = 0;
    idle(2);
    chk("bp_accepts", acc_cnt - a0, 4);
    chk("bp_rdy_low", lpm_rdy, 0);
    p0 = pop_cnt;
    rd_arp_result = 1; idle(6); rd_arp_result = 0;
    chk("bp_results", pop_cnt - p0, 4);
    chk("bp_rdy_back", lpm_rdy, 1);

    // Write during the compare cycle: lookup sees the old entry
    wr(5, 32'h0E000005, 48'h111111111111, 1, 1);
    next_hop_ip = 32'h0E000005; lpm_output_port = 8'h20; lpm_hit = 0; lpm_vld = 1;
    step();
    lpm_vld = 0;
    arp_wr_addr = 3'd5; arp_wr_ip = 32'h0E000005; arp_wr_mac = 48'h222222222222;
    arp_wr_valid = 1; arp_wr_static = 1; arp_wr_req = 1;
    step();
    arp_wr_req = 0;
    chk("wl_old_mac", next_hop_mac, 48'h111111111111);
    pop1();
    lkp(32'h0E000005, 8'h20, 0);
    chk("wl_new_mac", next_hop_mac, 48'h222222222222);
    pop1();

    // Reset mid-stream
    next_hop_ip = 32'h0E000005; lpm_vld = 1; idle(3); lpm_vld = 0;
    do_reset();
    chk("mid_rst_vld", arp_mac_vld, 0);
    chk("mid_rst_counts", {arp_hit_count, arp_miss_count}, 0);

    // Randomized traffic
    for (int k = 0; k < 4; k++) ips[k] = 32'h0A000100 + k;
    for (int n = 0; n < 3000; n++) begin
      reset         = ($urandom_range(0, 499) == 0);
      lpm_vld       = ($urandom_range(0, 1) == 1);
      next_hop_ip   = ($urandom_range(0, 7) == 0) ? $urandom : ips[$urandom_range(0, 3)];
      lpm_output_port = 8'($urandom);
      lpm_hit       = 1'($urandom);
      rd_arp_result = ($urandom_range(0, 2) != 0);
      arp_rd_req    = ($urandom_range(0, 3) == 0);
      arp_rd_addr   = 3'($urandom);
      arp_wr_req    = ($urandom_range(0, 5) == 0);
      arp_wr_addr   = 3'($urandom);
      arp_wr_ip     = ips[$urandom_range(0, 3)];
      arp_wr_mac    = {16'($urandom), 32'($urandom)};
      arp_wr_valid  = ($urandom_range(0, 7) != 0);
      arp_wr_static = 1'($urandom);
      step();
    end
    reset = 0; lpm_vld = 0; arp_rd_req = 0; arp_wr_req = 0;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
